// File: rtl/mux_pkg.sv
// mux_pkg: shared defaults, packet-lock state type and round-robin search helper for mux_rr_stream.
package mux_pkg;
  localparam int N_DEF = 4;
  localparam int WIDTH_DEF = 8;
  typedef enum logic {IDLE, LOCKED} lock_state_t;
  // Returns {found, idx}: first set req bit at or above ptr, wrapping modulo n (n <= 16, ptr < n).
  function automatic logic [4:0] rr_next(input logic [3:0] ptr, input logic [15:0] req, input int n);
    logic [4:0] r;
    int j;
    r = '0;
    for (int k = 15; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= n) j -= n;
      if (k < n && req[j[3:0]]) r = {1'b1, j[3:0]};
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin / forced-channel grant selection.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            force_en,
  input  logic [SELW-1:0] force_sel,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);
  logic [4:0] rr;
  logic force_ok;
  assign rr = rr_next(4'(ptr), 16'(req), N);
  always_comb begin
    force_ok = (int'(force_sel) < N) ? req[force_sel] : 1'b0;
    gnt_valid = force_en ? force_ok : rr[4];
    gnt_idx = force_en ? force_sel : SELW'(rr[3:0]);
  end
endmodule

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-channel round-robin/forced stream mux with a one-beat registered output.
// Define MUX_RR_PKT_EN to hold the grant on one channel until its in_last beat.
module mux_rr_stream
  import mux_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [N-1:0]      in_last,
  input  logic              force_en,
  input  logic [SELW-1:0]   force_sel,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  output logic [SELW-1:0]   out_sel,
  output logic              out_last,
  input  logic              out_ready
);
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [SELW-1:0] out_sel_q, out_sel_d, ptr_q, ptr_d;
  logic arb_force_en, gnt_valid, load, xfer;
  logic [SELW-1:0] arb_force_sel, gnt_idx, nxt;
`ifdef MUX_RR_PKT_EN
  lock_state_t lock_q, lock_d;
  logic [SELW-1:0] lk_q, lk_d;
  logic glast;
  // While locked, the arbiter is pinned to the lock channel via its forced path.
  assign arb_force_en = (lock_q == LOCKED) ? 1'b1 : force_en;
  assign arb_force_sel = (lock_q == LOCKED) ? lk_q : force_sel;
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign arb_force_en = force_en;
  assign arb_force_sel = force_sel;
`endif
  rr_arbiter #(.N(N)) u_arb (
    .req(in_valid),
    .ptr(ptr_q),
    .force_en(arb_force_en),
    .force_sel(arb_force_sel),
    .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx)
  );
  assign in_ready = xfer ? N'(1) << gnt_idx : '0;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel = out_sel_q;
  assign out_last = out_last_q;
  always_comb begin
    load = !out_valid_q || out_ready;
    xfer = gnt_valid && load && !rst;
    nxt = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    out_data_d = xfer ? in_data[gnt_idx*WIDTH +: WIDTH] : out_data_q;
    out_sel_d = xfer ? gnt_idx : out_sel_q;
    out_valid_d = xfer || (out_valid_q && !out_ready);
`ifdef MUX_RR_PKT_EN
    glast = in_last[gnt_idx];
    out_last_d = xfer ? glast : out_last_q;
    ptr_d = ptr_q;
    lock_d = lock_q;
    lk_d = lk_q;
    if (xfer && lock_q == LOCKED) begin
      lock_d = glast ? IDLE : LOCKED;
      ptr_d = glast ? nxt : ptr_q;
    end else if (xfer) begin
      ptr_d = force_en ? ptr_q : nxt;
      lock_d = glast ? IDLE : LOCKED;
      lk_d = glast ? lk_q : gnt_idx;
    end
`else
    out_last_d = 1'b0;
    ptr_d = (xfer && !force_en) ? nxt : ptr_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      out_sel_q <= '0;
      out_last_q <= 1'b0;
      ptr_q <= '0;
`ifdef MUX_RR_PKT_EN
      lock_q <= IDLE;
      lk_q <= '0;
`endif
    end else begin
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q <= out_sel_d;
      out_last_q <= out_last_d;
      ptr_q <= ptr_d;
`ifdef MUX_RR_PKT_EN
      lock_q <= lock_d;
      lk_q <= lk_d;
`endif
    end
  end
endmodule

// File: tb/tb_mux_rr_stream.sv
// tb_mux_rr_stream: directed and random checks of mux_rr_stream against a behavioural model.
module tb_mux_rr_stream;
  localparam int N = 4;
  localparam int WIDTH = 8;
  localparam int SELW = 2;
  logic clk, rst, force_en, out_valid, out_last, out_ready;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0] in_valid, in_ready, in_last;
  logic [SELW-1:0] force_sel, out_sel;
  logic [WIDTH-1:0] out_data;
  int checks = 0, failures = 0;
  int m_ptr, m_lk;
  bit m_lock, m_valid, m_last;
  int m_sel;
  logic [WIDTH-1:0] m_data;

  mux_rr_stream #(.N(N), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .force_en(force_en), .force_sel(force_sel), .out_data(out_data),
    .out_valid(out_valid), .out_sel(out_sel), .out_last(out_last), .out_ready(out_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (m_lock) return in_valid[m_lk] ? m_lk : -1;
    if (force_en) return (int'(force_sel) < N && in_valid[force_sel]) ? int'(force_sel) : -1;
    for (int k = 0; k < N; k++)
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (rst) begin
      m_ptr = 0; m_lock = 0; m_lk = 0; m_valid = 0; m_last = 0; m_sel = 0; m_data = '0;
    end else if (g >= 0 && (!m_valid || out_ready)) begin
      m_data = in_data[g*WIDTH +: WIDTH];
      m_sel = g;
      m_valid = 1;
`ifdef MUX_RR_PKT_EN
      m_last = in_last[g];
      if (m_lock) begin
        if (in_last[g]) begin
          m_lock = 0;
          m_ptr = (m_lk + 1) % N;
        end
      end else begin
        if (!force_en) m_ptr = (g + 1) % N;
        if (!in_last[g]) begin
          m_lock = 1;
          m_lk = g;
        end
      end
`else
      if (!force_en) m_ptr = (g + 1) % N;
`endif
    end else if (out_ready) m_valid = 0;
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step();
    int g;
    logic [N-1:0] er;
    #1;
    g = model_grant();
    er = '0;
    if (!rst && g >= 0 && (!m_valid || out_ready)) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    model_update(g);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    chk("out_last", 32'(out_last), 32'(m_last));
    @(negedge clk);
  endtask

  initial begin
    int seq [5] = '{0, 1, 2, 3, 0};
    rst = 1; force_en = 0; force_sel = '0; out_ready = 1; in_last = '0; in_valid = '1;
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 8'hA0 + 8'(i);
    m_ptr = 0; m_lock = 0; m_lk = 0; m_valid = 0; m_last = 0; m_sel = 0; m_data = '0;
    @(negedge clk);
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_seq_sel", 32'(out_sel), 32'(seq[i]));
      chk("rr_seq_data", 32'(out_data), 32'(8'hA0 + 8'(seq[i])));
    end
    step();
    chk("pre_bp_data", 32'(out_data), 32'h A1);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data", 32'(out_data), 32'hA1);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1;
    step();
    chk("bp_release_sel", 32'(out_sel), 2);
    chk("bp_release_valid", 32'(out_valid), 1);
    force_en = 1; force_sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("force_data", 32'(out_data), 32'hA3);
    end
    force_en = 0; in_valid = 4'b1010;
    step(); chk("sparse_0", 32'(out_sel), 3);
    step(); chk("sparse_1", 32'(out_sel), 1);
    step(); chk("sparse_2", 32'(out_sel), 3);
`ifdef MUX_RR_PKT_EN
    in_valid = 4'b0110; in_last = 4'b0000;
    step(); chk("pkt_b1_sel", 32'(out_sel), 1); chk("pkt_b1_last", 32'(out_last), 0);
    step(); chk("pkt_b2_sel", 32'(out_sel), 1); chk("pkt_b2_last", 32'(out_last), 0);
    in_last = 4'b0010;
    step(); chk("pkt_b3_sel", 32'(out_sel), 1); chk("pkt_b3_last", 32'(out_last), 1);
    in_last = 4'b0000;
    step(); chk("pkt_next_sel", 32'(out_sel), 2); chk("pkt_next_last", 32'(out_last), 0);
    rst = 1;
    step(); chk("pkt_rst_valid", 32'(out_valid), 0);
    rst = 0; in_valid = 4'b1000;
    step(); chk("pkt_after_rst_sel", 32'(out_sel), 3);
`endif
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      in_valid = N'($urandom);
      in_last = N'($urandom);
      in_data = ($urandom << 0);
      out_ready = ($urandom_range(0, 3) != 0);
      force_en = ($urandom_range(0, 5) == 0);
      force_sel = SELW'($urandom_range(0, N - 1));
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_rr_stream.md
# mux_rr_stream

Parametrised N-channel, WIDTH-bit stream multiplexer: the registered, handshaked successor of the 2:1 combinational mux. It arbitrates N valid/ready input channels round-robin, or forces a single channel when a force select is asserted, and drives one registered output stream. It sits between multiple producers and a shared consumer, for example a shared bus or an output port.

## Interface
Parameters:
- `N`, default 4: number of input channels, 2..16.
- `WIDTH`, default 8: data width per channel, ≥1.
- `SELW`, default `$clog2(N)`: select width. Derived; never overridden.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_data`, in, N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`, in, N: per-channel valid.
- `in_ready`, out, N: per-channel ready. One-hot or zero.
- `in_last`, in, N: per-channel end-of-packet. Used only under `MUX_RR_PKT_EN`.
- `force_en`, in, 1: 1 selects forced mode; 0 selects round-robin.
- `force_sel`, in, SELW: channel used in forced mode.
- `out_data`, out, WIDTH: registered output data.
- `out_valid`, out, 1: registered output valid.
- `out_sel`, out, SELW: source channel of the current `out_data`.
- `out_last`, out, 1: registered copy of the accepted `in_last`. Constant 0 when the packet feature is off.
- `out_ready`, in, 1: consumer ready.

## Operation
- **Output register.** One output register holds one beat.
  - `load = !out_valid || out_ready`.
  - A transfer on channel i means `in_valid[i] && in_ready[i]`.
- **Grant.** Combinational.
  - Round-robin: the first channel with `in_valid` set, scanning from `ptr` upward modulo N.
  - Forced: `force_sel` if `in_valid[force_sel]`, else none.
  - `force_sel ≥ N`: no grant.
- **Ready.** `in_ready[g] = load` for the granted channel g. All other `in_ready` bits are 0.
- **On a transfer from channel g:**
  - `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`, `out_last <= in_last[g]`.
  - `ptr <= (g+1) mod N`. The pointer wraps from N-1 to 0.
- **No transfer, `out_ready` high:** `out_valid <= 0`. `out_data` and `out_sel` hold.
- **Back-pressure.** While `out_valid && !out_ready`, the output holds stable and all `in_ready` bits are 0.
- **Pointer in forced mode.** The pointer does not advance. Round-robin resumes from the stored `ptr`.
- **Arithmetic.** Channel index arithmetic is modulo N. N need not be a power of two.

## Timing
- Latency: input beat accepted at edge k is visible on `out_*` after edge k.
- Throughput: one beat per cycle while `out_ready` stays high.
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `out_last`=0, `ptr`=0, lock state IDLE. While `rst` is high, `in_ready`=0.
- Reset mid-operation: an in-flight beat or packet is dropped, and there is no partial output afterwards.
- Simultaneous accept-and-drain: `out_ready`=1 and a new grant in the same cycle → the register reloads, and `out_valid` stays 1 with no bubble.
- `force_en`/`force_sel` may change in any cycle. The change takes effect the same cycle, except in packet mode while LOCKED.

## Configuration
Macro `MUX_RR_PKT_EN`.

Defined: packet lock is compiled in.
- States: IDLE, LOCKED.
- IDLE → LOCKED on a transfer with `in_last[g]`=0. The lock channel `lk` becomes g.
- While LOCKED, the grant is `lk` only. Other channels, `force_en` and `force_sel` are ignored. `ptr` does not advance.
- LOCKED → IDLE on a transfer from `lk` with `in_last`=1. At that transfer `ptr <= (lk+1) mod N`.
- A single-beat packet, `in_last`=1 in IDLE, stays IDLE.
- `out_last` mirrors the accepted beat.

Not defined:
- Arbitration is per beat.
- `in_last` is unused.
- `out_last` is tied to 0.

## Structure
- Shared package `mux_pkg`: parameter defaults, `lock_state_t` enum (IDLE, LOCKED), and a `rr_next(ptr, req)` function.
- One sub-module, `rr_arbiter` (parameter N), with ports `req[N]`, `ptr`, `force_en`, `force_sel`, `gnt_valid`, `gnt_idx`. It is purely combinational.
- The top module holds the output register, `ptr` and the lock FSM.

## Test plan
- **Reset.** Hold `rst` 2 cycles with all inputs valid → `out_valid`=0, `out_data`=0, `in_ready`=0. First grant after reset goes to channel 0.
- **Round-robin fairness.** N=4, all `in_valid`=1, channel i data = 8'hA0+i, `out_ready`=1 → `out_sel` sequence 0,1,2,3,0 on consecutive cycles. `out_data` = A0,A1,A2,A3,A0.
- **Back-pressure.** `out_ready`=0 for 3 cycles with `out_data`=8'hA1 → output holds A1, `in_ready`=0. On release, the next beat is from channel 2 with no bubble.
- **Forced mode.** `force_en`=1, `force_sel`=3, all valid → only channel 3 is accepted (A3 every cycle). After `force_en` drops, round-robin resumes at the stored `ptr`.
- **Wrap and sparse requests.** `ptr`=3, only channels 1 and 3 valid → grants 3, then 1, then 3.
- **Packet lock (`MUX_RR_PKT_EN`).** Channel 1 sends a 3-beat packet (last on beat 3) while channel 2 is valid → channel 2 is not granted until after beat 3. `out_last`=1 on beat 3 only. Asserting `rst` mid-packet returns the block to IDLE with `out_valid`=0.
